// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and default timing.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    // Counter width that stays at least one bit wide for degenerate parameter values.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular word buffer between the upstream handshake and the transmit shifter.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    assign full_o      = (r_count == CNT_W'(DEPTH));
    assign empty_o     = (r_count == '0);
    assign count_o     = r_count;
    assign head_data_o = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffered UART transmitter: words enter through a valid/ready FIFO and leave as
// start/data/stop frames on a registered serial line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned UART_DATA_WIDTH = 8,
    parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       uart_rsp_val_i,
    input  logic [UART_DATA_WIDTH-1:0] uart_rsp_data_i,
    output logic                       uart_rsp_rdy_o,
    output logic                       tx_o,
    output logic                       busy_o
);

    localparam int unsigned BAUD_W = clog2_min1(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = clog2_min1(UART_DATA_WIDTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_WIDTH - 1);

    uart_state_e                r_state;
    uart_state_e                w_state_next;
    logic [BAUD_W-1:0]          r_baud;
    logic [BAUD_W-1:0]          w_baud_next;
    logic [IDX_W-1:0]           r_bit_idx;
    logic [IDX_W-1:0]           w_bit_idx_next;
    logic [UART_DATA_WIDTH-1:0] r_shift;
    logic [UART_DATA_WIDTH-1:0] w_shift_next;
    logic                       r_tx;
    logic                       w_tx_next;
    logic                       r_busy;
    logic                       w_busy_next;
    logic                       r_rdy_en;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [CNT_W-1:0]           w_fifo_count;
    logic [UART_DATA_WIDTH-1:0] w_head;
    logic                       w_baud_done;
    logic                       w_fifo_nonempty_next;

    // Ready depends only on registered state; r_rdy_en holds it low until the first edge out of reset.
    assign uart_rsp_rdy_o = r_rdy_en && !w_fifo_full;
    assign w_push         = uart_rsp_val_i && uart_rsp_rdy_o;
    assign w_baud_done    = (r_baud == BAUD_LAST);
    assign tx_o           = r_tx;
    assign busy_o         = r_busy;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i (uart_rsp_data_i),
        .pop_i       (w_pop),
        .head_data_o (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_baud_done) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_baud_done && (r_bit_idx == IDX_LAST)) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_baud_done) w_state_next = w_fifo_empty ? ST_IDLE : ST_START;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop          = 1'b0;
        w_baud_next    = r_baud + BAUD_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IDX_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                    end
                end
            end
            default: w_baud_next = '0;
        endcase

        // Line level is derived from the next state so the register lands on the same edge.
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase

        w_fifo_nonempty_next = w_push || (w_fifo_count > CNT_W'(w_pop));
        w_busy_next          = (w_state_next != ST_IDLE) || w_fifo_nonempty_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_rdy_en  <= 1'b0;
        end else begin
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_rdy_en  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed and randomized checks of the buffered UART transmitter (4 clocks/bit, 4-deep FIFO).
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       uart_rsp_val_i;
    logic [7:0] uart_rsp_data_i;
    logic       uart_rsp_rdy_o;
    logic       tx_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit         rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_stop_err = 0;
    logic [7:0] exp_q[$];

    uart_tx_serializer #(
        .UART_DATA_WIDTH (8),
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .uart_rsp_val_i  (uart_rsp_val_i),
        .uart_rsp_data_i (uart_rsp_data_i),
        .uart_rsp_rdy_o  (uart_rsp_rdy_o),
        .tx_o            (tx_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one frame cycle by cycle; exp holds the line level per bit slot, slot 0 = start bit.
    task automatic check_frame(input string tag, input logic [9:0] exp, input int first_cycle);
        for (int c = first_cycle; c < 10 * CPB; c++) begin
            check($sformatf("%s_c%0d", tag, c), {31'd0, tx_o}, {31'd0, exp[c / CPB]});
            tick();
        end
    endtask

    // Line receiver: samples each data bit mid-slot and the stop bit near its end.
    initial begin : rx_model
        bit         active;
        int         cnt;
        logic [7:0] sh;
        active = 1'b0;
        cnt    = 0;
        sh     = '0;
        forever begin
            @(negedge clk_i);
            if (!rx_en) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx_o === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if (cnt >= 6 && cnt <= 34 && (cnt % 4) == 2) sh[(cnt - 6) / 4] = tx_o;
                if (cnt == 38) begin
                    rx_q.push_back(sh);
                    if (tx_o !== 1'b1) rx_stop_err++;
                end
                if (cnt == 39) active = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit         acc;

        rst_ni          = 1'b0;
        uart_rsp_val_i  = 1'b0;
        uart_rsp_data_i = 8'h00;

        // Reset behaviour
        repeat (3) tick();
        check("rst_tx",   {31'd0, tx_o},           32'd1);
        check("rst_rdy",  {31'd0, uart_rsp_rdy_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o},         32'd0);
        rst_ni = 1'b1;
        #1;
        check("rdy_before_edge", {31'd0, uart_rsp_rdy_o}, 32'd0);
        tick();
        check("rdy_after_release", {31'd0, uart_rsp_rdy_o}, 32'd1);

        // Single byte 0xA5
        uart_rsp_val_i  = 1'b1;
        uart_rsp_data_i = 8'hA5;
        tick();
        uart_rsp_val_i = 1'b0;
        check("a5_tx_at_accept", {31'd0, tx_o},   32'd1);
        check("a5_busy",         {31'd0, busy_o}, 32'd1);
        tick();
        check_frame("a5", 10'b11_0100_1010, 0);
        check("a5_busy_after", {31'd0, busy_o}, 32'd0);
        check("a5_tx_after",   {31'd0, tx_o},   32'd1);

        // Back-to-back 0x00, 0xFF, 0x3C
        uart_rsp_val_i  = 1'b1;
        uart_rsp_data_i = 8'h00;
        tick();
        uart_rsp_data_i = 8'hFF;
        tick();
        check("b2b_start", {31'd0, tx_o}, 32'd0);
        uart_rsp_data_i = 8'h3C;
        tick();
        uart_rsp_val_i = 1'b0;
        check_frame("b2b_00", 10'b10_0000_0000, 1);
        check_frame("b2b_ff", 10'b11_1111_1110, 0);
        check_frame("b2b_3c", 10'b10_0111_1000, 0);
        check("b2b_busy_after", {31'd0, busy_o}, 32'd0);

        // Burst of six words: five accepted before ready drops
        uart_rsp_val_i  = 1'b1;
        uart_rsp_data_i = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("burst_rdy_%0d", i), {31'd0, uart_rsp_rdy_o}, 32'd1);
            tick();
            uart_rsp_data_i = 8'(i + 1);
        end
        check("burst_rdy_full", {31'd0, uart_rsp_rdy_o}, 32'd0);
        check_frame("burst_01", 10'b10_0000_0010, 3);
        check("burst_rdy_reopen", {31'd0, uart_rsp_rdy_o}, 32'd1);
        check("burst_02_start",   {31'd0, tx_o},           32'd0);
        tick();
        uart_rsp_val_i = 1'b0;
        check("burst_rdy_refull", {31'd0, uart_rsp_rdy_o}, 32'd0);
        check_frame("burst_02", 10'b10_0000_0100, 1);
        check_frame("burst_03", 10'b10_0000_0110, 0);
        check_frame("burst_04", 10'b10_0000_1000, 0);
        check_frame("burst_05", 10'b10_0000_1010, 0);
        check_frame("burst_06", 10'b10_0000_1100, 0);
        check("burst_busy_after", {31'd0, busy_o}, 32'd0);

        // Random stream with valid gaps, decoded from the line
        rx_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            uart_rsp_val_i = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            b               = 8'($urandom);
            uart_rsp_val_i  = 1'b1;
            uart_rsp_data_i = b;
            acc             = 1'b0;
            for (int w = 0; w < 500 && !acc; w++) begin
                acc = (uart_rsp_rdy_o === 1'b1);
                tick();
            end
            if (!acc) begin
                check("rand_accept_timeout", 32'd0, 32'd1);
                break;
            end
            exp_q.push_back(b);
        end
        uart_rsp_val_i = 1'b0;
        for (int w = 0; w < 3000 && busy_o !== 1'b0; w++) tick();
        check("rand_drain_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) tick();
        rx_en = 1'b0;
        check("rand_rx_count", rx_q.size(), 32'd200);
        check("rand_stop_bits", rx_stop_err, 32'd0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("rand_byte_%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end

        // Reset during data bit 3 of 0x55 with two words queued
        uart_rsp_val_i  = 1'b1;
        uart_rsp_data_i = 8'h55;
        tick();
        uart_rsp_data_i = 8'h11;
        tick();
        uart_rsp_data_i = 8'h22;
        tick();
        uart_rsp_val_i = 1'b0;
        repeat (16) tick();
        check("mid_bit3_line", {31'd0, tx_o}, 32'd0);
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_tx",   {31'd0, tx_o},           32'd1);
        check("mid_rst_rdy",  {31'd0, uart_rsp_rdy_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o},         32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check("mid_rel_rdy",  {31'd0, uart_rsp_rdy_o}, 32'd1);
        check("mid_rel_busy", {31'd0, busy_o},         32'd0);
        for (int c = 0; c < 60; c++) begin
            check($sformatf("mid_quiet_%0d", c), {30'd0, busy_o, tx_o}, 32'd1);
            tick();
        end
        uart_rsp_val_i  = 1'b1;
        uart_rsp_data_i = 8'h81;
        tick();
        uart_rsp_val_i = 1'b0;
        tick();
        check_frame("post_rst_81", 10'b11_0000_0010, 0);
        check("post_rst_busy", {31'd0, busy_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
